// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM state type, default parameters and address-split helpers for data_memory_pipe
package dmem_pkg;
  typedef enum logic {ST_INIT, ST_RUN} state_e;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DEPTH = 256;
  localparam int DEF_READ_LAT = 1;
  function automatic int ofs_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction
  function automatic int idx_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/dmem_rd_pipe.sv
// dmem_rd_pipe: READ_LAT-deep valid/data/err delay line; data and err are zero on idle slots
module dmem_rd_pipe #(
  parameter int DATA_W = 32,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_err,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err
);
  logic [READ_LAT-1:0] v_q, e_q;
  logic [READ_LAT-1:0][DATA_W-1:0] d_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      e_q <= '0;
      d_q <= '0;
    end else begin
      v_q[0] <= in_valid;
      e_q[0] <= in_valid & in_err;
      d_q[0] <= (in_valid && !in_err) ? in_data : '0;
      for (int i = 1; i < READ_LAT; i++) begin
        v_q[i] <= v_q[i-1];
        e_q[i] <= e_q[i-1];
        d_q[i] <= d_q[i-1];
      end
    end
  end
  assign out_valid = v_q[READ_LAT-1];
  assign out_err   = e_q[READ_LAT-1];
  assign out_data  = d_q[READ_LAT-1];
endmodule

// File: rtl/data_memory_pipe.sv
// data_memory_pipe: byte-enabled word memory with a clearing INIT phase, error flagging
// and a fixed-latency in-order read response pipe
module data_memory_pipe
  import dmem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int READ_LAT = DEF_READ_LAT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_err,
  output logic [15:0]         err_count
);
  localparam int BYTES = DATA_W / 8;
  localparam int OFS = ofs_w(DATA_W);
  localparam int IW = idx_w(DEPTH);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH * BYTES);
  state_e state_q, state_d;
  logic [IW-1:0] clr_q, clr_d, idx;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic acc, err;
  assign idx = req_addr[OFS +: IW];
  // Mask test instead of a slice so the misalignment check degenerates to 0 for byte-wide words
  assign err = ((req_addr & ADDR_W'(BYTES - 1)) != '0) || ({1'b0, req_addr} >= LIMIT);
  assign req_ready = state_q == ST_RUN;
  assign acc = req_valid && req_ready;
  assign err_count = err_cnt_q;
  always_comb begin
    state_d = (state_q == ST_INIT && clr_q == IW'(DEPTH - 1)) ? ST_RUN : state_q;
    clr_d = (state_q == ST_INIT) ? clr_q + IW'(1) : clr_q;
    err_cnt_d = (acc && err && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      clr_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      clr_q <= clr_d;
      err_cnt_q <= err_cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT)
      mem[clr_q] <= '0;
    else if (acc && req_we && !err)
      for (int b = 0; b < BYTES; b++)
        if (req_be[b]) mem[idx][8*b +: 8] <= req_wdata[8*b +: 8];
  end
  dmem_rd_pipe #(.DATA_W(DATA_W), .READ_LAT(READ_LAT)) u_rd_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (acc && !req_we),
    .in_data  (mem[idx]),
    .in_err   (err),
    .out_valid(rsp_valid),
    .out_data (rsp_data),
    .out_err  (rsp_err)
  );
endmodule

// File: tb/tb_data_memory_pipe.sv
// tb_data_memory_pipe: randomized and directed checks of two instances (READ_LAT 1 and 3)
// against a word-array reference model with response due-slots
module tb_data_memory_pipe;
  localparam int DEPTH = 256;
  typedef struct {
    bit r, v, we;
    logic [31:0] a, d;
    logic [3:0] be;
  } req_t;
  logic clk = 0, rst = 1, req_valid = 0, req_we = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [3:0] req_be = 0;
  logic req_ready1, rsp_valid1, rsp_err1, req_ready3, rsp_valid3, rsp_err3;
  logic [31:0] rsp_data1, rsp_data3;
  logic [15:0] err_count1, err_count3;
  int nchk = 0, nerr = 0, cyc = 0, init_left = DEPTH;
  bit m_ready = 0;
  logic [15:0] m_cnt = 0;
  logic [31:0] m_mem [DEPTH];
  bit due_v1 [8], due_e1 [8], due_v3 [8], due_e3 [8];
  logic [31:0] due_d1 [8], due_d3 [8];
  bit e1_v, e1_e, e3_v, e3_e;
  logic [31:0] e1_d, e3_d;
  always #5 clk = ~clk;
  data_memory_pipe #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .READ_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready1), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid1),
    .rsp_data(rsp_data1), .rsp_err(rsp_err1), .err_count(err_count1));
  data_memory_pipe #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .READ_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready3), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid3),
    .rsp_data(rsp_data3), .rsp_err(rsp_err3), .err_count(err_count3));
  // A read accepted at edge n is visible after edge n+LAT-1, so it lands in slot n+LAT-1
  task automatic tick();
    bit bad;
    @(posedge clk);
    cyc++;
    if (rst) begin
      init_left = DEPTH;
      m_ready = 0;
      m_cnt = 0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      for (int i = 0; i < 8; i++) begin
        due_v1[i] = 0;
        due_v3[i] = 0;
      end
    end else begin
      if (m_ready && req_valid) begin
        bad = (req_addr % 4 != 0) || (req_addr >= DEPTH * 4);
        if (bad && m_cnt != 16'hFFFF) m_cnt++;
        if (req_we && !bad)
          for (int b = 0; b < 4; b++)
            if (req_be[b]) m_mem[req_addr/4][8*b +: 8] = req_wdata[8*b +: 8];
        if (!req_we) begin
          due_v1[cyc%8] = 1;
          due_e1[cyc%8] = bad;
          due_d1[cyc%8] = bad ? 32'h0 : m_mem[req_addr/4];
          due_v3[(cyc+2)%8] = 1;
          due_e3[(cyc+2)%8] = bad;
          due_d3[(cyc+2)%8] = bad ? 32'h0 : m_mem[req_addr/4];
        end
      end
      if (init_left > 0) init_left--;
      m_ready = init_left == 0;
    end
    e1_v = due_v1[cyc%8];
    e1_e = e1_v && due_e1[cyc%8];
    e1_d = e1_v ? due_d1[cyc%8] : 32'h0;
    e3_v = due_v3[cyc%8];
    e3_e = e3_v && due_e3[cyc%8];
    e3_d = e3_v ? due_d3[cyc%8] : 32'h0;
    due_v1[cyc%8] = 0;
    due_v3[cyc%8] = 0;
    @(negedge clk);
  endtask
  task automatic drive(input req_t q);
    rst = q.r;
    req_valid = q.v;
    req_we = q.we;
    req_addr = q.a;
    req_wdata = q.d;
    req_be = q.be;
    tick();
  endtask
  function automatic req_t rq(bit r, bit v, bit we, logic [31:0] a, logic [31:0] d, logic [3:0] be);
    return '{r, v, we, a, d, be};
  endfunction
  task automatic test_reset();
    req_t s[$];
    for (int i = 0; i < 3; i++) s.push_back(rq(1, 0, 0, 0, 0, 0));
    for (int i = 0; i < DEPTH; i++) s.push_back(rq(0, 0, 0, 0, 0, 0));
    s.push_back(rq(0, 1, 0, 32'h40, 0, 0));
    for (int i = 0; i < 3; i++) s.push_back(rq(0, 0, 0, 0, 0, 0));
    foreach (s[i]) begin
      drive(s[i]);
      if ({rsp_valid1, rsp_err1, rsp_data1} !== {e1_v, e1_e, e1_d}) begin nerr++; $display("FAIL reset lat1 rsp cyc %0d: got v=%b e=%b d=%h want v=%b e=%b d=%h", cyc, rsp_valid1, rsp_err1, rsp_data1, e1_v, e1_e, e1_d); end
      if ({rsp_valid3, rsp_err3, rsp_data3} !== {e3_v, e3_e, e3_d}) begin nerr++; $display("FAIL reset lat3 rsp cyc %0d: got v=%b e=%b d=%h want v=%b e=%b d=%h", cyc, rsp_valid3, rsp_err3, rsp_data3, e3_v, e3_e, e3_d); end
      if ({req_ready1, req_ready3} !== {2{m_ready}}) begin nerr++; $display("FAIL reset ready cyc %0d: got %b%b want %b", cyc, req_ready1, req_ready3, m_ready); end
      if ({err_count1, err_count3} !== {2{m_cnt}}) begin nerr++; $display("FAIL reset err_count cyc %0d: got %0d/%0d want %0d", cyc, err_count1, err_count3, m_cnt); end
      nchk += 4;
      if (i < 3) begin
        nchk++;
        if ({req_ready1, rsp_valid1, rsp_err1, rsp_data1, err_count1, req_ready3, rsp_valid3, rsp_err3, rsp_data3, err_count3} !== '0) begin nerr++; $display("FAIL reset_state cyc %0d: outputs not all zero", cyc); end
      end
      if (i >= 3 && i <= 258) begin
        nchk++;
        if (req_ready1 !== (i == 258)) begin nerr++; $display("FAIL init_ready step %0d: got %b want %b", i - 3, req_ready1, i == 258); end
      end
      if (i == 259) begin
        nchk++;
        if ({rsp_valid1, rsp_err1, rsp_data1} !== {2'b10, 32'h0}) begin nerr++; $display("FAIL idle_read lat1: got v=%b e=%b d=%h want v=1 e=0 d=0", rsp_valid1, rsp_err1, rsp_data1); end
      end
      if (i == 261) begin
        nchk++;
        if ({rsp_valid3, rsp_err3, rsp_data3} !== {2'b10, 32'h0}) begin nerr++; $display("FAIL idle_read lat3: got v=%b e=%b d=%h want v=1 e=0 d=0", rsp_valid3, rsp_err3, rsp_data3); end
      end
    end
  endtask
  task automatic test_write_read();
    req_t s[$];
    s = '{rq(0, 1, 1, 32'h10, 32'hDEADBEEF, 4'hF), rq(0, 1, 0, 32'h10, 0, 0), rq(0, 0, 0, 0, 0, 0), rq(0, 0, 0, 0, 0, 0),
          rq(0, 1, 1, 32'h10, 32'h11223344, 4'b0101), rq(0, 1, 0, 32'h10, 0, 0), rq(0, 0, 0, 0, 0, 0), rq(0, 0, 0, 0, 0, 0)};
    foreach (s[i]) begin
      drive(s[i]);
      if ({rsp_valid1, rsp_err1, rsp_data1} !== {e1_v, e1_e, e1_d}) begin nerr++; $display("FAIL write_read lat1 rsp cyc %0d: got v=%b e=%b d=%h want v=%b e=%b d=%h", cyc, rsp_valid1, rsp_err1, rsp_data1, e1_v, e1_e, e1_d); end
      if ({rsp_valid3, rsp_err3, rsp_data3} !== {e3_v, e3_e, e3_d}) begin nerr++; $display("FAIL write_read lat3 rsp cyc %0d: got v=%b e=%b d=%h want v=%b e=%b d=%h", cyc, rsp_valid3, rsp_err3, rsp_data3, e3_v, e3_e, e3_d); end
      if ({req_ready1, req_ready3} !== {2{m_ready}}) begin nerr++; $display("FAIL write_read ready cyc %0d: got %b%b want %b", cyc, req_ready1, req_ready3, m_ready); end
      if ({err_count1, err_count3} !== {2{m_cnt}}) begin nerr++; $display("FAIL write_read err_count cyc %0d: got %0d/%0d want %0d", cyc, err_count1, err_count3, m_cnt); end
      nchk += 4;
      if (i == 1 || i == 5) begin
        nchk++;
        if (rsp_data1 !== (i == 1 ? 32'hDEADBEEF : 32'hDE22BE44)) begin nerr++; $display("FAIL raw_data lat1 step %0d: got %h", i, rsp_data1); end
      end
      if (i == 3 || i == 7) begin
        nchk++;
        if (rsp_data3 !== (i == 3 ? 32'hDEADBEEF : 32'hDE22BE44)) begin nerr++; $display("FAIL raw_data lat3 step %0d: got %h", i, rsp_data3); end
      end
    end
  endtask
  task automatic test_errors();
    req_t s[$];
    s = '{rq(0, 1, 0, 32'h12, 0, 0), rq(0, 1, 1, 32'h400, 32'hFFFFFFFF, 4'hF), rq(0, 1, 0, 32'h10, 0, 0), rq(0, 1, 0, 32'h0, 0, 0),
          rq(0, 0, 0, 0, 0, 0), rq(0, 0, 0, 0, 0, 0), rq(0, 1, 1, 32'h11, 32'h0, 4'hF), rq(0, 1, 0, 32'h10, 0, 0),
          rq(0, 0, 0, 0, 0, 0), rq(0, 0, 0, 0, 0, 0)};
    foreach (s[i]) begin
      drive(s[i]);
      if ({rsp_valid1, rsp_err1, rsp_data1} !== {e1_v, e1_e, e1_d}) begin nerr++; $display("FAIL errors lat1 rsp cyc %0d: got v=%b e=%b d=%h want v=%b e=%b d=%h", cyc, rsp_valid1, rsp_err1, rsp_data1, e1_v, e1_e, e1_d); end
      if ({rsp_valid3, rsp_err3, rsp_data3} !== {e3_v, e3_e, e3_d}) begin nerr++; $display("FAIL errors lat3 rsp cyc %0d: got v=%b e=%b d=%h want v=%b e=%b d=%h", cyc, rsp_valid3, rsp_err3, rsp_data3, e3_v, e3_e, e3_d); end
      if ({req_ready1, req_ready3} !== {2{m_ready}}) begin nerr++; $display("FAIL errors ready cyc %0d: got %b%b want %b", cyc, req_ready1, req_ready3, m_ready); end
      if ({err_count1, err_count3} !== {2{m_cnt}}) begin nerr++; $display("FAIL errors err_count cyc %0d: got %0d/%0d want %0d", cyc, err_count1, err_count3, m_cnt); end
      nchk += 4;
      if (i == 0) begin
        nchk++;
        if ({rsp_valid1, rsp_err1, rsp_data1} !== {2'b11, 32'h0}) begin nerr++; $display("FAIL misaligned_rsp: got v=%b e=%b d=%h want v=1 e=1 d=0", rsp_valid1, rsp_err1, rsp_data1); end
      end
      if (i == 1 || i == 2 || i == 3 || i == 7) begin
        nchk++;
        if (rsp_data1 !== (i == 1 ? 32'h0 : i == 3 ? 32'h0 : 32'hDE22BE44)) begin nerr++; $display("FAIL err_no_write step %0d: got %h", i, rsp_data1); end
      end
      if (i == 5 || i == 9) begin
        nchk++;
        if ({err_count1, err_count3} !== {2{i == 5 ? 16'd2 : 16'd3}}) begin nerr++; $display("FAIL err_count_value step %0d: got %0d/%0d", i, err_count1, err_count3); end
      end
    end
  endtask
  task automatic test_back_to_back();
    req_t s[$];
    logic [31:0] exp_b [4] = '{32'h11111111, 32'hDE22BE44, 32'h22222222, 32'h33333333};
    int first = -1, n = 0;
    s = '{rq(0, 1, 1, 32'h0, 32'h11111111, 4'hF), rq(0, 1, 1, 32'h20, 32'h22222222, 4'hF), rq(0, 1, 1, 32'h40, 32'h33333333, 4'hF),
          rq(0, 1, 0, 32'h0, 0, 0), rq(0, 1, 0, 32'h10, 0, 0), rq(0, 1, 0, 32'h20, 0, 0), rq(0, 1, 0, 32'h40, 0, 0)};
    for (int i = 0; i < 4; i++) s.push_back(rq(0, 0, 0, 0, 0, 0));
    foreach (s[i]) begin
      drive(s[i]);
      if ({rsp_valid1, rsp_err1, rsp_data1} !== {e1_v, e1_e, e1_d}) begin nerr++; $display("FAIL b2b lat1 rsp cyc %0d: got v=%b e=%b d=%h want v=%b e=%b d=%h", cyc, rsp_valid1, rsp_err1, rsp_data1, e1_v, e1_e, e1_d); end
      if ({rsp_valid3, rsp_err3, rsp_data3} !== {e3_v, e3_e, e3_d}) begin nerr++; $display("FAIL b2b lat3 rsp cyc %0d: got v=%b e=%b d=%h want v=%b e=%b d=%h", cyc, rsp_valid3, rsp_err3, rsp_data3, e3_v, e3_e, e3_d); end
      if ({req_ready1, req_ready3} !== {2{m_ready}}) begin nerr++; $display("FAIL b2b ready cyc %0d: got %b%b want %b", cyc, req_ready1, req_ready3, m_ready); end
      if ({err_count1, err_count3} !== {2{m_cnt}}) begin nerr++; $display("FAIL b2b err_count cyc %0d: got %0d/%0d want %0d", cyc, err_count1, err_count3, m_cnt); end
      nchk += 4;
      if (rsp_valid3 === 1'b1) begin
        if (first < 0) first = i;
        n++;
      end
      if (i >= 5 && i <= 8) begin
        nchk++;
        if ({rsp_valid3, rsp_data3} !== {1'b1, exp_b[i-5]}) begin nerr++; $display("FAIL b2b_order step %0d: got v=%b d=%h want v=1 d=%h", i, rsp_valid3, rsp_data3, exp_b[i-5]); end
      end
    end
    nchk++;
    if (first != 5 || n != 4) begin nerr++; $display("FAIL b2b_burst: got first=%0d count=%0d want first=5 count=4", first, n); end
  endtask
  task automatic test_reset_inflight();
    req_t s[$];
    int late = 0;
    s = '{rq(0, 1, 1, 32'h30, 32'hCAFEF00D, 4'hF), rq(0, 1, 0, 32'h10, 0, 0), rq(0, 1, 0, 32'h30, 0, 0), rq(1, 0, 0, 0, 0, 0), rq(1, 0, 0, 0, 0, 0)};
    for (int i = 0; i < DEPTH; i++) s.push_back(rq(0, 0, 0, 0, 0, 0));
    s.push_back(rq(0, 1, 0, 32'h30, 0, 0));
    s.push_back(rq(0, 1, 0, 32'h10, 0, 0));
    for (int i = 0; i < 3; i++) s.push_back(rq(0, 0, 0, 0, 0, 0));
    foreach (s[i]) begin
      drive(s[i]);
      if ({rsp_valid1, rsp_err1, rsp_data1} !== {e1_v, e1_e, e1_d}) begin nerr++; $display("FAIL inflight lat1 rsp cyc %0d: got v=%b e=%b d=%h want v=%b e=%b d=%h", cyc, rsp_valid1, rsp_err1, rsp_data1, e1_v, e1_e, e1_d); end
      if ({rsp_valid3, rsp_err3, rsp_data3} !== {e3_v, e3_e, e3_d}) begin nerr++; $display("FAIL inflight lat3 rsp cyc %0d: got v=%b e=%b d=%h want v=%b e=%b d=%h", cyc, rsp_valid3, rsp_err3, rsp_data3, e3_v, e3_e, e3_d); end
      if ({req_ready1, req_ready3} !== {2{m_ready}}) begin nerr++; $display("FAIL inflight ready cyc %0d: got %b%b want %b", cyc, req_ready1, req_ready3, m_ready); end
      if ({err_count1, err_count3} !== {2{m_cnt}}) begin nerr++; $display("FAIL inflight err_count cyc %0d: got %0d/%0d want %0d", cyc, err_count1, err_count3, m_cnt); end
      nchk += 4;
      if (i >= 3 && i <= 260 && (rsp_valid1 !== 1'b0 || rsp_valid3 !== 1'b0)) late++;
      if (i >= 5 && i <= 260) begin
        nchk++;
        if (req_ready3 !== (i == 260)) begin nerr++; $display("FAIL reinit_ready step %0d: got %b want %b", i - 5, req_ready3, i == 260); end
      end
      if (i == 261 || i == 262) begin
        nchk++;
        if ({rsp_valid1, rsp_data1} !== {1'b1, 32'h0}) begin nerr++; $display("FAIL cleared_word step %0d: got v=%b d=%h want v=1 d=0", i, rsp_valid1, rsp_data1); end
      end
    end
    nchk++;
    if (late != 0) begin nerr++; $display("FAIL flush_inflight: got %0d stray responses want 0", late); end
  endtask
  task automatic test_random();
    req_t q;
    int r;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      q = rq(0, $urandom_range(0, 3) != 0, $urandom_range(0, 1), 0, $urandom, 4'($urandom_range(0, 15)));
      q.a = r < 6 ? 32'($urandom_range(0, 15) * 4) : r == 6 ? 32'($urandom_range(0, DEPTH - 1) * 4) :
            r == 7 ? 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3)) : 32'(DEPTH * 4 + $urandom_range(0, 255));
      drive(q);
      if ({rsp_valid1, rsp_err1, rsp_data1} !== {e1_v, e1_e, e1_d}) begin nerr++; $display("FAIL random lat1 rsp cyc %0d: got v=%b e=%b d=%h want v=%b e=%b d=%h", cyc, rsp_valid1, rsp_err1, rsp_data1, e1_v, e1_e, e1_d); end
      if ({rsp_valid3, rsp_err3, rsp_data3} !== {e3_v, e3_e, e3_d}) begin nerr++; $display("FAIL random lat3 rsp cyc %0d: got v=%b e=%b d=%h want v=%b e=%b d=%h", cyc, rsp_valid3, rsp_err3, rsp_data3, e3_v, e3_e, e3_d); end
      if ({req_ready1, req_ready3} !== {2{m_ready}}) begin nerr++; $display("FAIL random ready cyc %0d: got %b%b want %b", cyc, req_ready1, req_ready3, m_ready); end
      if ({err_count1, err_count3} !== {2{m_cnt}}) begin nerr++; $display("FAIL random err_count cyc %0d: got %0d/%0d want %0d", cyc, err_count1, err_count3, m_cnt); end
      nchk += 4;
    end
  endtask
  initial begin
    test_reset();
    test_write_read();
    test_errors();
    test_back_to_back();
    test_reset_inflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
